// File: rtl/layer_stream_receiver.sv
// Strips and checks the preamble of an inter-layer frame, re-emits data words tagged with keep/run/word position.
// Latency 1 cycle, one word per cycle; no backpressure (the sender has no ready), framing faults are pulsed instead.
module layer_stream_receiver #(
    parameter int LOG2_PARALLEL_BITWIDTH   = 8,
    parameter int LOG2_PARALLELISM         = 4,
    parameter int NUM_LAYERS               = 3,
    parameter int MAX_LAYER_ENTRIES        = 300,
    parameter int PREAMBLE_CYCLES_BITWIDTH = 16,
    localparam int W  = 1 << LOG2_PARALLEL_BITWIDTH,
    localparam int L  = 1 << LOG2_PARALLELISM,
    localparam int E  = $clog2(MAX_LAYER_ENTRIES),
    localparam int WI = (MAX_LAYER_ENTRIES / L > 1) ? $clog2(MAX_LAYER_ENTRIES / L) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [W-1:0]                        input_mdata,
    input  logic                                input_mvalid,
    input  logic                                input_mlast,
    input  logic [NUM_LAYERS-1:0]               input_layer,
    input  logic [E-1:0]                        input_layer_entries,
    input  logic [PREAMBLE_CYCLES_BITWIDTH-1:0] preamble_cycle_length,
    output logic [W-1:0]                        output_tdata,
    output logic [L-1:0]                        output_tkeep,
    output logic                                output_tvalid,
    output logic                                output_tfirst,
    output logic                                output_tlast,
    output logic [WI-1:0]                       output_word_index,
    output logic [E:0]                          output_run_index,
    output logic [NUM_LAYERS-1:0]               output_layer,
    output logic [E:0]                          output_run_count,
    output logic                                preamble_error,
    output logic                                gap_error,
    output logic                                frame_error
);
    localparam int PCB = PREAMBLE_CYCLES_BITWIDTH;
    localparam int CW  = E + 2;

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA} state_t;

    state_t         state;
    logic [E-1:0]   entries_q;
    logic [PCB-1:0] preamble_q;
    logic [PCB-1:0] pre_cnt;
    logic [E-1:0]   word_idx;
    logic [E:0]     run_idx;

    logic [E-1:0]   ent_sel;
    logic [CW-1:0]  ent_eff;
    logic [CW-1:0]  words_last;
    logic [L-1:0]   last_keep;
    logic [L-1:0]   one_l;
    logic [PCB-1:0] pre_cnt_nxt;
    logic           all_ones;
    logic           is_final;
    logic           is_run_end;
    logic           data_word;

    // In IDLE the frame parameters are not latched yet, so the live inputs describe the first word.
    always_comb begin
        ent_sel     = (state == S_IDLE) ? input_layer_entries : entries_q;
        ent_eff     = (ent_sel == '0) ? CW'(1) : CW'(ent_sel);
        words_last  = ((ent_eff + CW'(L - 1)) >> LOG2_PARALLELISM) - CW'(1);
        one_l       = {{(L-1){1'b0}}, 1'b1};
        last_keep   = (ent_eff[LOG2_PARALLELISM-1:0] == '0) ? '1
                    : (one_l << ent_eff[LOG2_PARALLELISM-1:0]) - one_l;
        pre_cnt_nxt = pre_cnt + PCB'(1);
        all_ones    = &input_mdata;
        is_final    = (&input_layer) && input_mlast;
        is_run_end  = ({2'b00, word_idx} == words_last);
        data_word   = input_mvalid &&
                      ((state == S_DATA) ||
                       (state == S_IDLE && !is_final && preamble_cycle_length == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            entries_q         <= '0;
            preamble_q        <= '0;
            pre_cnt           <= '0;
            word_idx          <= '0;
            run_idx           <= '0;
            output_tdata      <= '0;
            output_tkeep      <= '0;
            output_tvalid     <= 1'b0;
            output_tfirst     <= 1'b0;
            output_tlast      <= 1'b0;
            output_word_index <= '0;
            output_run_index  <= '0;
            output_layer      <= '0;
            output_run_count  <= '0;
            preamble_error    <= 1'b0;
            gap_error         <= 1'b0;
            frame_error       <= 1'b0;
        end else begin
            output_tvalid  <= 1'b0;
            output_tfirst  <= 1'b0;
            output_tlast   <= 1'b0;
            preamble_error <= 1'b0;
            gap_error      <= 1'b0;
            frame_error    <= 1'b0;

            if (data_word) begin
                output_tdata      <= input_mdata;
                output_tkeep      <= is_run_end ? last_keep : '1;
                output_tvalid     <= 1'b1;
                output_tfirst     <= (word_idx == '0);
                output_tlast      <= input_mlast;
                output_word_index <= word_idx[WI-1:0];
                output_run_index  <= run_idx;
                if (input_mlast) begin
                    output_run_count <= run_idx + (E+1)'(1);
                    frame_error      <= !is_run_end;
                    state            <= S_IDLE;
                    word_idx         <= '0;
                    run_idx          <= '0;
                end else begin
                    state <= S_DATA;
                    if (is_run_end) begin
                        word_idx <= '0;
                        run_idx  <= run_idx + (E+1)'(1);
                    end else begin
                        word_idx <= word_idx + E'(1);
                    end
                end
            end

            case (state)
                S_IDLE: begin
                    if (input_mvalid) begin
                        entries_q    <= input_layer_entries;
                        preamble_q   <= preamble_cycle_length;
                        output_layer <= input_layer;
                        if (is_final) begin
                            output_tdata      <= input_mdata;
                            output_tkeep      <= last_keep;
                            output_tvalid     <= 1'b1;
                            output_tfirst     <= 1'b1;
                            output_tlast      <= 1'b1;
                            output_word_index <= '0;
                            output_run_index  <= '0;
                            output_run_count  <= (E+1)'(1);
                        end else if (preamble_cycle_length == '0) begin
                            // first word is data; handled by the data path above
                        end else if (all_ones && !input_mlast) begin
                            pre_cnt <= PCB'(1);
                            state   <= (preamble_cycle_length == PCB'(1)) ? S_DATA : S_PREAMBLE;
                        end else begin
                            preamble_error <= 1'b1;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (input_mvalid && all_ones && !input_mlast) begin
                        pre_cnt <= pre_cnt_nxt;
                        if (pre_cnt_nxt == preamble_q)
                            state <= S_DATA;
                    end else begin
                        preamble_error <= 1'b1;
                        pre_cnt        <= '0;
                        state          <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!input_mvalid) begin
                        gap_error <= 1'b1;
                        word_idx  <= '0;
                        run_idx   <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_stream_receiver.sv
// Directed vector bench for layer_stream_receiver: each record is one input word and the outputs expected one cycle later.
module tb_layer_stream_receiver;
    logic         clk;
    logic         rst;
    logic [255:0] input_mdata;
    logic         input_mvalid;
    logic         input_mlast;
    logic [2:0]   input_layer;
    logic [8:0]   input_layer_entries;
    logic [15:0]  preamble_cycle_length;
    logic [255:0] output_tdata;
    logic [15:0]  output_tkeep;
    logic         output_tvalid;
    logic         output_tfirst;
    logic         output_tlast;
    logic [4:0]   output_word_index;
    logic [9:0]   output_run_index;
    logic [2:0]   output_layer;
    logic [9:0]   output_run_count;
    logic         preamble_error;
    logic         gap_error;
    logic         frame_error;

    layer_stream_receiver dut (
        .clk                   (clk),
        .rst                   (rst),
        .input_mdata           (input_mdata),
        .input_mvalid          (input_mvalid),
        .input_mlast           (input_mlast),
        .input_layer           (input_layer),
        .input_layer_entries   (input_layer_entries),
        .preamble_cycle_length (preamble_cycle_length),
        .output_tdata          (output_tdata),
        .output_tkeep          (output_tkeep),
        .output_tvalid         (output_tvalid),
        .output_tfirst         (output_tfirst),
        .output_tlast          (output_tlast),
        .output_word_index     (output_word_index),
        .output_run_index      (output_run_index),
        .output_layer          (output_layer),
        .output_run_count      (output_run_count),
        .preamble_error        (preamble_error),
        .gap_error             (gap_error),
        .frame_error           (frame_error)
    );

    typedef struct {
        logic         vld;
        logic         last;
        logic [255:0] dat;
        logic [2:0]   layer;
        logic [8:0]   ent;
        logic [15:0]  pre;
        logic         e_vld;
        logic [15:0]  e_keep;
        logic         e_first;
        logic         e_last;
        logic [4:0]   e_widx;
        logic [9:0]   e_ridx;
        logic [9:0]   e_rcnt;
        logic [2:0]   e_err;   // {preamble, gap, frame}
    } vec_t;

    vec_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          tag = 0;
    logic [2:0]  cur_layer;
    logic [8:0]  cur_ent;
    logic [15:0] cur_pre;
    logic [9:0]  rc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] word(input int k);
        logic [255:0] w;
        for (int i = 0; i < 16; i++) w[16*i +: 16] = 16'(k * 256 + i + 1);
        return w;
    endfunction

    task automatic push(input logic vld, input logic last, input logic [255:0] dat,
                        input logic e_vld, input logic [15:0] e_keep, input logic e_first,
                        input logic e_last, input logic [4:0] e_widx, input logic [9:0] e_ridx,
                        input logic [2:0] e_err);
        vec_t v;
        v.vld = vld; v.last = last; v.dat = dat;
        v.layer = cur_layer; v.ent = cur_ent; v.pre = cur_pre;
        v.e_vld = e_vld; v.e_keep = e_keep; v.e_first = e_first; v.e_last = e_last;
        v.e_widx = e_widx; v.e_ridx = e_ridx; v.e_rcnt = rc; v.e_err = e_err;
        q.push_back(v);
    endtask

    task automatic idle_v(input logic [2:0] err);
        push(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, err);
    endtask

    task automatic pre_v();
        push(1'b1, 1'b0, '1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 3'b000);
    endtask

    task automatic dat_v(input logic [255:0] dat, input logic last, input logic [15:0] keep,
                         input logic first, input logic [4:0] widx, input logic [9:0] ridx,
                         input logic [2:0] err);
        push(1'b1, last, dat, 1'b1, keep, first, last, widx, ridx, err);
    endtask

    task automatic apply(input vec_t v);
        logic [302:0] got;
        logic [302:0] exp;
        @(negedge clk);
        input_mvalid          = v.vld;
        input_mlast           = v.last;
        input_mdata           = v.dat;
        input_layer           = v.layer;
        input_layer_entries   = v.ent;
        preamble_cycle_length = v.pre;
        @(posedge clk);
        #1;
        got = {output_tvalid, output_tfirst, output_tlast, preamble_error, gap_error, frame_error,
               output_run_count,
               v.e_vld ? {output_tkeep, output_word_index, output_run_index, output_tdata} : 287'd0};
        exp = {v.e_vld, v.e_first, v.e_last, v.e_err, v.e_rcnt,
               v.e_vld ? {v.e_keep, v.e_widx, v.e_ridx, v.dat} : 287'd0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL vec%0d: got %h required %h", tag, got, exp);
        end
        tag++;
    endtask

    task automatic run_q();
        for (int i = 0; i < q.size(); i++) apply(q[i]);
        q.delete();
    endtask

    task automatic check_zero(input string name);
        logic [305:0] got;
        got = {output_tdata, output_tkeep, output_tvalid, output_tfirst, output_tlast,
               output_word_index, output_run_index, output_layer, output_run_count,
               preamble_error, gap_error, frame_error};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s: got %h required 0", name, got);
        end
    endtask

    initial begin
        rst = 1'b1;
        input_mvalid = 1'b0; input_mlast = 1'b0; input_mdata = '0;
        input_layer = '0; input_layer_entries = '0; preamble_cycle_length = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        cur_layer = 3'b001; cur_ent = 9'd20; cur_pre = 16'd4; rc = '0;
        // Normal frame: 4 preamble words, 6 data words, C=2
        repeat (4) pre_v();
        dat_v(word(1), 0, 16'hFFFF, 1, 0, 0, 3'b000);
        dat_v(word(2), 0, 16'h000F, 0, 1, 0, 3'b000);
        dat_v(word(3), 0, 16'hFFFF, 1, 0, 1, 3'b000);
        dat_v(word(4), 0, 16'h000F, 0, 1, 1, 3'b000);
        dat_v(word(5), 0, 16'hFFFF, 1, 0, 2, 3'b000);
        rc = 10'd3;
        dat_v(word(6), 1, 16'h000F, 0, 1, 2, 3'b000);
        idle_v(3'b000);
        // Bad preamble: third word is zero, then a good short frame
        pre_v(); pre_v();
        push(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 3'b100);
        idle_v(3'b000);
        repeat (4) pre_v();
        dat_v(word(7), 0, 16'hFFFF, 1, 0, 0, 3'b000);
        rc = 10'd1;
        dat_v(word(8), 1, 16'h000F, 0, 1, 0, 3'b000);
        // Gap after 3 data words, back to back with the previous frame
        repeat (4) pre_v();
        dat_v(word(9),  0, 16'hFFFF, 1, 0, 0, 3'b000);
        dat_v(word(10), 0, 16'h000F, 0, 1, 0, 3'b000);
        dat_v(word(11), 0, 16'hFFFF, 1, 0, 1, 3'b000);
        idle_v(3'b010);
        // Misaligned end on the 3rd data word
        repeat (4) pre_v();
        dat_v(word(12), 0, 16'hFFFF, 1, 0, 0, 3'b000);
        dat_v(word(13), 0, 16'h000F, 0, 1, 0, 3'b000);
        rc = 10'd2;
        dat_v(word(14), 1, 16'hFFFF, 1, 0, 1, 3'b001);
        // Final-layer single-word frame, straight after mlast
        cur_layer = 3'b111; cur_ent = 9'd1; rc = 10'd1;
        dat_v(word(15), 1, 16'h0001, 1, 0, 0, 3'b000);
        // P=0: all-ones first word is data
        cur_layer = 3'b001; cur_ent = 9'd20; cur_pre = 16'd0;
        dat_v('1, 0, 16'hFFFF, 1, 0, 0, 3'b000);
        dat_v(word(16), 1, 16'h000F, 0, 1, 0, 3'b000);
        idle_v(3'b000);
        // P=1 with early mlast, then a non-preamble word in IDLE
        cur_pre = 16'd1;
        pre_v();
        dat_v(word(17), 1, 16'hFFFF, 1, 0, 0, 3'b001);
        push(1'b1, 1'b0, word(18), 1'b0, '0, 1'b0, 1'b0, '0, '0, 3'b100);
        // Enter DATA ahead of an asynchronous reset
        cur_pre = 16'd4;
        repeat (4) pre_v();
        dat_v(word(19), 0, 16'hFFFF, 1, 0, 0, 3'b000);
        dat_v(word(20), 0, 16'h000F, 0, 1, 0, 3'b000);
        run_q();

        // Async reset between clock edges
        input_mvalid = 1'b0;
        input_mlast  = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        #1 rst = 1'b0;

        rc = '0;
        idle_v(3'b000);
        repeat (4) pre_v();
        dat_v(word(21), 0, 16'hFFFF, 1, 0, 0, 3'b000);
        rc = 10'd1;
        dat_v(word(22), 1, 16'h000F, 0, 1, 0, 3'b000);
        idle_v(3'b000);
        run_q();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/layer_stream_receiver.md
# layer_stream_receiver

Receive side of the inter-layer wide-word protocol. Consumes the framed stream a layer buffer emits (preamble of all-ones words, then repeated runs of packed data words, `mlast` on the final word; or a bare single-word final-layer frame), strips and checks the preamble, and re-emits data words with per-lane keep masks and run/word position tags. It also reports framing errors. Sits on the photonic-side ingress / loopback path and feeds downstream per-run consumers.

## Interface
Parameters:
- LOG2_PARALLEL_BITWIDTH, 8, log2 of word width W (256).
- LOG2_PARALLELISM, 4, log2 of lanes L (16); lane width V = W/L (16).
- NUM_LAYERS, 3, width of the one-hot layer tag; all-ones means the final layer.
- MAX_LAYER_ENTRIES, 300, max values per run; E = clog2(MAX_LAYER_ENTRIES).
- PREAMBLE_CYCLES_BITWIDTH, 16, width of the preamble length.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous and active-high; one clock domain.
- input_mdata  in  W  packed word; lane i = bits [V*i+V-1 : V*i].
- input_mvalid  in  1  word valid. No backpressure.
- input_mlast  in  1  last word of frame.
- input_layer  in  NUM_LAYERS  layer tag of the sender.
- input_layer_entries  in  E  values per run (0 treated as 1).
- preamble_cycle_length  in  PREAMBLE_CYCLES_BITWIDTH  expected preamble words P.
- output_tdata  out  W  data word.
- output_tkeep  out  L  lane valid mask.
- output_tvalid  out  1  data valid.
- output_tfirst  out  1  first word of a run.
- output_tlast  out  1  last word of frame.
- output_word_index  out  clog2(MAX_LAYER_ENTRIES/L)  word index within run.
- output_run_index  out  E+1  run index.
- output_layer  out  NUM_LAYERS  layer tag latched at frame start.
- output_run_count  out  E+1  runs in last completed frame.
- preamble_error, gap_error, frame_error  out  1 each  one-cycle pulses.

## Operation
- C = ceil(entries/L). Last-word keep = (entries mod L == 0) ? all-ones : (1 << (entries mod L)) - 1. Every other word has keep all-ones.
- Frame-start sampling: `input_layer`, `input_layer_entries` and `preamble_cycle_length` are sampled on the first valid word of a frame and held until the frame ends.
- State IDLE. Valid word arriving:
  - input_layer all-ones and mlast: FINAL frame. Emit the word with last-word keep, tfirst=1, tlast=1, run_count=1. Stay IDLE.
  - Else P == 0: the word is the first data word. Go to DATA.
  - Else word is all-ones: go to PREAMBLE with count=1, or straight to DATA-pending if P == 1.
  - Else: preamble_error pulse. Word is dropped.
- State PREAMBLE:
  - Each valid all-ones word increments count. When count reaches P, go to DATA; the next valid word is data even if it is all-ones.
  - A non-all-ones word, mlast before data, or mvalid low: preamble_error, return to IDLE.
- State DATA:
  - Each valid word is emitted with the current word_idx and run_idx. tfirst = (word_idx == 0).
  - word_idx wraps at C-1; run_idx increments on the wrap.
  - mvalid low mid-frame: gap_error, return to IDLE, no tlast.
  - On mlast: emit with tlast and set run_count = run_idx+1. If word_idx != C-1, pulse frame_error. Return to IDLE.
- Reset values: every output register is 0. The state machine goes to IDLE and all counters clear. Reset mid-frame discards the frame with no error pulse.

## Timing
- All outputs are registered. Latency is exactly 1 cycle from input word to output word.
- Throughput is one word per cycle.
- output_tvalid is low whenever no word is emitted. output_tdata holds its last value.
- Error pulses are 1 cycle wide, registered, and coincide with the cycle after the offending input.
- Back-to-back frames are allowed. A new frame's first word may arrive the cycle after mlast.

## Test plan
- Normal frame: P=4, entries=20 (C=2). Send 4 all-ones words, then 6 data words with mlast on the 6th.
  - Required: 6 outputs, each 1 cycle after its input.
  - keep alternates 0xFFFF / 0x000F; tfirst on words 0, 2, 4; run_index 0,0,1,1,2,2.
  - tlast on the 6th output; run_count=3; no errors.
- Bad preamble: P=4, the third preamble word is 0x0.
  - Required: preamble_error pulse, no tvalid.
  - A following correct frame is received normally.
- Gap: mvalid drops after 3 data words.
  - Required: 3 outputs, gap_error, no tlast; the next frame is clean.
- Misaligned end: entries=20, mlast on the 3rd data word.
  - Required: tlast on that word, frame_error, run_count=2.
- Final and zero-preamble frames:
  - input_layer=3'b111, entries=1, single word with mlast and no preamble: one output, keep 0x0001, tfirst=tlast=1.
  - P=0: the first word, even all-ones, is emitted as data.
- Async reset mid-DATA: assert rst with no clock edge.
  - Required: outputs go to 0 immediately, no error pulse, next frame received correctly.
